// File: rtl/mem_req_pkg.sv
// mem_req_pkg: shared types and helpers for the MEM-stage data-memory initiator.
//   op_e    - load/store access type as encoded by the decoder
//   state_e - initiator FSM states
//   is_store(), is_misaligned() - decode helpers used by the top and the bench
package mem_req_pkg;

  typedef enum logic [2:0] {
    LW  = 3'd0,
    LH  = 3'd1,
    LHU = 3'd2,
    LB  = 3'd3,
    LBU = 3'd4,
    SW  = 3'd5,
    SH  = 3'd6,
    SB  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic is_store(input op_e op);
    return (op == SW) || (op == SH) || (op == SB);
  endfunction

  // Words need both low address bits clear, halfwords only bit 0.
  function automatic logic is_misaligned(input op_e op, input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    case (op)
      LW, SW:      mis = (off != 2'b00);
      LH, LHU, SH: mis = off[0];
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_lane_ext.sv
// mem_lane_ext: combinational load-data extract and extend.
//   op_i   - access type (op_e encoding)
//   off_i  - byte offset addr[1:0]
//   word_i - aligned 32-bit word read from memory
//   data_o - byte/halfword selected and sign/zero extended; LW (and stores)
//            pass the word through unchanged
module mem_lane_ext
  import mem_req_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] word_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    case (off_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
    half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
  end

  always_comb begin
    data_o = word_i;
    case (op_e'(op_i))
      LB:      data_o = {{24{byte_sel[7]}}, byte_sel};
      LBU:     data_o = {24'h0, byte_sel};
      LH:      data_o = {{16{half_sel[15]}}, half_sel};
      LHU:     data_o = {16'h0, half_sel};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_req_master.sv
// mem_req_master: MEM-stage initiator for the data-memory port.
// Accepts one load/store per instruction, issues a word-aligned req/ack
// transaction, stalls the pipeline until it completes and returns the
// extended load result with a one-cycle done pulse.
//   clk, reset (sync, active-high)
//   op_valid_i/op_i/addr_i/wdata_i/pc_i - pipeline request
//   stall_o, done_o, rd_data_o, exc_adel_o, exc_ades_o, err_timeout_o - pipeline response
//   mem_req_o/mem_we_o/mem_addr_o/mem_be_o/mem_wdata_o, mem_ack_i/mem_rdata_i - memory port
//   trace_pc_o - PC of the access in flight, for the golden-trace monitor
//
// state  | meaning
// IDLE   | waiting for a load/store from the pipeline
// REQ    | request on the memory port, waiting for ack or timeout
// DONE   | one-cycle completion; results/exception flags valid
module mem_req_master
  import mem_req_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] pc_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] rd_data_o,
  output logic        exc_adel_o,
  output logic        exc_ades_o,
  output logic        err_timeout_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] trace_pc_o
);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       rd_data_q, rd_data_d;
  logic              adel_q, adel_d;
  logic              ades_q, ades_d;
  logic              tmo_q, tmo_d;

  logic [31:0]       ld_data;
  logic [3:0]        st_be;
  logic [31:0]       st_wdata;
  logic              in_req;
  op_e               op_in;

  assign op_in = op_e'(op_i);

  mem_lane_ext u_lane_ext (
    .op_i   (op_q),
    .off_i  (addr_q[1:0]),
    .word_i (mem_rdata_i),
    .data_o (ld_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_q      <= LW;
      addr_q    <= '0;
      wdata_q   <= '0;
      pc_q      <= '0;
      cnt_q     <= '0;
      rd_data_q <= '0;
      adel_q    <= 1'b0;
      ades_q    <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      rd_data_q <= rd_data_d;
      adel_q    <= adel_d;
      ades_q    <= ades_d;
      tmo_q     <= tmo_d;
    end
  end

  // Exception/timeout flags are only ever set on the transition into DONE,
  // so defaulting them to 0 makes them single-cycle, aligned with done.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    pc_d      = pc_q;
    cnt_d     = cnt_q;
    rd_data_d = rd_data_q;
    adel_d    = 1'b0;
    ades_d    = 1'b0;
    tmo_d     = 1'b0;
    stall_o   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (op_valid_i) begin
          stall_o = 1'b1;
          if (is_misaligned(op_in, addr_i[1:0])) begin
            state_d = S_DONE;
            if (is_store(op_in)) ades_d = 1'b1;
            else                 adel_d = 1'b1;
          end else begin
            state_d = S_REQ;
            op_d    = op_in;
            addr_d  = addr_i;
            wdata_d = wdata_i;
            pc_d    = pc_i;
            cnt_d   = '0;
          end
        end
      end
      S_REQ: begin
        stall_o = 1'b1;
        if (mem_ack_i) begin
          state_d = S_DONE;
          if (!is_store(op_q)) rd_data_d = ld_data;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d   = S_DONE;
          tmo_d     = 1'b1;
          rd_data_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    st_be    = 4'b0000;
    st_wdata = '0;
    case (op_q)
      SB: begin
        st_be    = 4'b0001 << addr_q[1:0];
        st_wdata = {4{wdata_q[7:0]}};
      end
      SH: begin
        st_be    = addr_q[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{wdata_q[15:0]}};
      end
      SW: begin
        st_be    = 4'b1111;
        st_wdata = wdata_q;
      end
      default: begin
        st_be    = 4'b0000;
        st_wdata = '0;
      end
    endcase
  end

  // Memory-port outputs are forced to 0 outside REQ so the bus is quiet
  // between transactions.
  assign in_req        = (state_q == S_REQ);
  assign mem_req_o     = in_req;
  assign mem_we_o      = in_req & is_store(op_q);
  assign mem_addr_o    = in_req ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_be_o      = in_req ? st_be : 4'b0000;
  assign mem_wdata_o   = in_req ? st_wdata : 32'h0;
  assign done_o        = (state_q == S_DONE);
  assign rd_data_o     = rd_data_q;
  assign exc_adel_o    = adel_q;
  assign exc_ades_o    = ades_q;
  assign err_timeout_o = tmo_q;
  assign trace_pc_o    = pc_q;

endmodule
